// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Booth recoding of {Q[0], q_1}; 00 and 11 leave the accumulator alone
   localparam logic [1:0] BP_ADD = 2'b01;
   localparam logic [1:0] BP_SUB = 2'b10;

   function automatic int booth_cnt_width(input int w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/subtract of M, then arithmetic right shift of {acc,Q,q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W:0] acc,
   input  logic [W:0] m,
   input  logic [W:0] q,
   input  logic       q_1,
   output logic [W:0] acc_nxt,
   output logic [W:0] q_nxt,
   output logic       q_1_nxt
);

   logic [W:0] sum;

   always_comb begin
      sum = acc;
      case ({q[0], q_1})
         BP_ADD:  sum = acc + m;
         BP_SUB:  sum = acc - m;
         default: sum = acc;
      endcase
   end

   assign {acc_nxt, q_nxt, q_1_nxt} = {sum[W], sum, q};

endmodule

// File: rtl/booth_multiply_seq.sv
// Sequential radix-2 Booth multiplier, W+1 iterations, valid/ready on both sides.
module booth_multiply_seq
   import booth_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = booth_cnt_width(DATA_WIDTH)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic                      signed_i,
   input  logic [DATA_WIDTH-1:0]     multiplicand_i,
   input  logic [DATA_WIDTH-1:0]     multiplier_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [2*DATA_WIDTH-1:0]   product_o,
   output logic                      busy_o
);

   localparam int W = DATA_WIDTH;

   state_t         state;
   logic [W:0]     acc, m, q;
   logic           q_1;
   logic [CNT_WIDTH-1:0] cnt;

   logic [W:0]     acc_nxt, q_nxt;
   logic           q_1_nxt;
   logic [2*W+1:0] full_nxt;
   logic [1:0]     unused_hi;
   logic           accept;

   booth_step #(.W(W)) u_step (
      .acc     (acc),
      .m       (m),
      .q       (q),
      .q_1     (q_1),
      .acc_nxt (acc_nxt),
      .q_nxt   (q_nxt),
      .q_1_nxt (q_1_nxt)
   );

   // The top two bits only carry the W+1-bit sign extension.
   assign full_nxt  = {acc_nxt, q_nxt};
   assign unused_hi = full_nxt[2*W+1:2*W];

   assign in_ready_o = (state == ST_IDLE) || ((state == ST_DONE) && out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= ST_IDLE;
         acc         <= '0;
         m           <= '0;
         q           <= '0;
         q_1         <= 1'b0;
         cnt         <= '0;
         product_o   <= '0;
         out_valid_o <= 1'b0;
         busy_o      <= 1'b0;
      end else if (accept) begin
         // Covers both IDLE accept and the back-to-back DONE retire+accept.
         m           <= {signed_i & multiplicand_i[W-1], multiplicand_i};
         q           <= {signed_i & multiplier_i[W-1], multiplier_i};
         acc         <= '0;
         q_1         <= 1'b0;
         cnt         <= CNT_WIDTH'(W + 1);
         state       <= ST_CALC;
         busy_o      <= 1'b1;
         out_valid_o <= 1'b0;
      end else begin
         case (state)
            ST_CALC: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               q_1 <= q_1_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_WIDTH'(1)) begin
                  product_o   <= full_nxt[2*W-1:0];
                  state       <= ST_DONE;
                  busy_o      <= 1'b0;
                  out_valid_o <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  state       <= ST_IDLE;
                  out_valid_o <= 1'b0;
               end
            end
            ST_IDLE: ;
            default: begin
               state       <= ST_IDLE;
               busy_o      <= 1'b0;
               out_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/booth_multiply_seq.md
Name: booth_multiply_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. It is the successor to the fixed 8-bit Booth FSMD multiplier.
- Adds a generic operand width, per-operation signed/unsigned mode, and valid/ready handshakes on input and output.
- Performs one combined add/subtract-and-shift iteration per clock.
- Sits between operand-producing logic and any consumer of 2W-bit products in the configurable multiplier datapath.

Parameters:
- DATA_WIDTH, 8, operand width W. Legal range is 4 to 32.
- CNT_WIDTH, $clog2(DATA_WIDTH+2), width of the iteration counter. It is derived and must not be overridden.

Ports:
- clk_i  input  1  sole clock; all state changes on the rising edge.
- reset_i  input  1  reset. The block has one clock; reset is asynchronous and active-high.
- in_valid_i  input  1  operands and mode are valid.
- in_ready_o  output  1  block can accept operands this cycle.
- signed_i  input  1  1 = both operands two's complement; 0 = both unsigned.
- multiplicand_i  input  DATA_WIDTH  multiplicand M.
- multiplier_i  input  DATA_WIDTH  multiplier Q.
- out_valid_o  output  1  product_o holds a finished result.
- out_ready_i  input  1  consumer accepts the result.
- product_o  output  2*DATA_WIDTH  product M*Q, signed or unsigned per the captured mode.
- busy_o  output  1  high in CALC.

Behaviour:
- Reset (asynchronous, while reset_i=1):
  - State goes to IDLE.
  - Accumulator, multiplier, q_1, counter and product register clear to 0.
  - out_valid_o=0, busy_o=0, in_ready_o=1 from the first edge after deassertion.
  - Reset mid-CALC or mid-DONE discards the operation; no result is ever presented for it.
- State IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1, capture operands into an internal width of W+1 bits. Bit W is the operand MSB when signed_i=1, otherwise 0.
  - Clear the accumulator (W+1 bits), set q_1=0, set the counter to W+1, and go to CALC.
  - With in_valid_i=0, stay in IDLE.
- State CALC (busy_o=1, in_ready_o=0):
  - On each edge, select acc' from {Q[0],q_1}: 01 -> acc+M; 10 -> acc-M; 00/11 -> acc.
  - Then arithmetic-right-shift {acc',Q,q_1} by one, replicating acc'[W] into the MSB.
  - The add/subtract uses W+1 bits and wraps modulo 2^(W+1); no overflow flag is required.
  - Decrement the counter. On the edge where the counter reaches 0, load product_o with the low 2W bits of {acc,Q} and go to DONE.
  - Latency: exactly W+1 CALC cycles. out_valid_o rises W+1 edges after the accepting edge, e.g. 9 cycles for W=8. Latency is independent of operand values and mode.
- State DONE:
  - out_valid_o=1; product_o is stable until the output handshake.
  - If out_ready_i=0, hold everything.
  - If out_ready_i=1 and in_valid_i=0, go to IDLE; out_valid_o drops on the next edge.
  - If out_ready_i=1 and in_valid_i=1, retire and accept on the same edge. This is back-to-back, with no IDLE bubble.
  - in_ready_o = out_ready_i in DONE. It is combinational from out_ready_i only.
- Output rules:
  - product_o is registered. It keeps its last value in IDLE/CALC and is only meaningful when out_valid_o=1.
  - in_valid_i is ignored while in_ready_o=0; operands need not be held after acceptance.
- Mode corner cases:
  - Unsigned all-ones operands are correct because of the W+1-bit extension.
  - Signed -2^(W-1) * -2^(W-1) equals 2^(2W-2) and fits in 2W bits.

Decomposition:
- Shared package booth_pkg: state encoding localparams ST_IDLE=2'b00, ST_CALC=2'b01, ST_DONE=2'b10; Booth pair codes; a function computing the CNT_WIDTH default.
- One sub-module, booth_step, is natural. It is combinational and W+1 bits wide. It takes acc, M, Q[0], q_1 and returns the shifted {acc,Q,q_1}.
- The top level holds the FSM, counter, registers and handshakes.

Test Plan:
- W=8, signed_i=1, M=-3 (8'hFD), Q=5 -> product_o=16'hFFF1 with out_valid_o exactly 9 cycles after accept.
- W=8, signed_i=0, M=Q=8'hFF -> 16'hFE01. Then signed_i=1 with the same bits -> 16'h0001.
- W=8, signed_i=1, M=Q=8'h80 -> 16'h4000. Also M=8'h7F, Q=8'h80 -> 16'hC080.
- Backpressure: out_ready_i=0 for 5 cycles in DONE -> product_o and out_valid_o held, in_ready_o=0. Then out_ready_i=1 with in_valid_i=1 (M=2, Q=3) -> same-edge accept; next result 16'h0006 after 9 cycles.
- Reset asserted at CALC cycle 4 -> immediate IDLE, out_valid_o=0, no stale result. A following 7*6 operation gives 16'h002A.
- Random sweep at DATA_WIDTH=4, 8 and 16, both modes, random out_ready_i -> every product matches a reference model; no lost or duplicated results.
